// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the main-memory arbiter.
//   LINE_W        - width of one cache line (4 x 32-bit words)
//   LINE_ADDR_W   - width of a line address
//   arb_state_t   - arbiter FSM states
//   req_id_t      - identifies which cache owns the current transaction
package mem_pkg;

  localparam int LINE_W      = 128;
  localparam int LINE_ADDR_W = 26;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_id_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I-cache and D-cache line requests onto a single-port
// RAM that answers combinationally. It adds a fixed LATENCY cycles per access
// and returns each completion as a one-cycle ready pulse.
//
// Ports:
//   clk, reset (async, active-low)
//   ic_req/ic_addr        -> I-cache line fill request (read only)
//   ic_ready/ic_line      <- I-cache completion pulse and returned line
//   dc_req/dc_we/dc_addr/dc_wdata -> D-cache fill (we=0) or writeback (we=1)
//   dc_ready/dc_line      <- D-cache completion pulse and returned line
//   mem_rd_addr/mem_rd_data       -> RAM read port
//   mem_wr_addr/mem_wr_data/mem_we -> RAM write port
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int LATENCY     = 5,
  parameter int LINE_ADDR_W = mem_pkg::LINE_ADDR_W,
  parameter int LINE_W      = mem_pkg::LINE_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ic_req,
  input  logic [LINE_ADDR_W-1:0] ic_addr,
  output logic                   ic_ready,
  output logic [LINE_W-1:0]      ic_line,
  input  logic                   dc_req,
  input  logic                   dc_we,
  input  logic [LINE_ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0]      dc_wdata,
  output logic                   dc_ready,
  output logic [LINE_W-1:0]      dc_line,
  output logic [LINE_ADDR_W-1:0] mem_rd_addr,
  input  logic [LINE_W-1:0]      mem_rd_data,
  output logic [LINE_ADDR_W-1:0] mem_wr_addr,
  output logic [LINE_W-1:0]      mem_wr_data,
  output logic                   mem_we
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [CW-1:0]          r_cnt;
  req_id_t                r_last_grant;
  req_id_t                r_id;
  logic [LINE_ADDR_W-1:0] r_addr;
  logic                   r_we;
  logic [LINE_W-1:0]      r_wdata;
  logic [LINE_W-1:0]      r_ic_line;
  logic [LINE_W-1:0]      r_dc_line;

  logic                   w_grant;
  req_id_t                w_grant_id;
  logic                   w_last_cycle;

  assign w_last_cycle = (r_state == BUSY) && (r_cnt == CNT_LAST);

  // Next-state and grant selection. Under contention the side that did not
  // win last time is served, so neither cache can starve the other.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_id  = REQ_I;
    case (r_state)
      IDLE: begin
        if (ic_req && dc_req) begin
          w_grant    = 1'b1;
          w_grant_id = (r_last_grant == REQ_I) ? REQ_D : REQ_I;
        end else if (ic_req) begin
          w_grant    = 1'b1;
          w_grant_id = REQ_I;
        end else if (dc_req) begin
          w_grant    = 1'b1;
          w_grant_id = REQ_D;
        end
        if (w_grant) begin
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_last_cycle) begin
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= REQ_I;
      r_id         <= REQ_I;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_ic_line    <= '0;
      r_dc_line    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          // Request inputs are frozen here for the rest of the transaction.
          if (w_grant) begin
            r_id <= w_grant_id;
            if (w_grant_id == REQ_D) begin
              r_addr  <= dc_addr;
              r_we    <= dc_we;
              r_wdata <= dc_wdata;
            end else begin
              r_addr <= ic_addr;
              r_we   <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (w_last_cycle) begin
            r_cnt <= '0;
            if (!r_we) begin
              if (r_id == REQ_I) begin
                r_ic_line <= mem_rd_data;
              end else begin
                r_dc_line <= mem_rd_data;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_last_grant <= r_id;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign ic_ready    = (r_state == RESP) && (r_id == REQ_I);
  assign dc_ready    = (r_state == RESP) && (r_id == REQ_D);
  assign ic_line     = r_ic_line;
  assign dc_line     = r_dc_line;
  assign mem_rd_addr = r_addr;
  assign mem_wr_addr = r_addr;
  assign mem_wr_data = r_wdata;
  // Combinational from state so an asynchronous reset drops it at once.
  assign mem_we      = w_last_cycle && r_we;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int AW = mem_pkg::LINE_ADDR_W;
  localparam int LW = mem_pkg::LINE_W;
  localparam logic [LW-1:0] LINE0    = {32'h00300193, 32'h00200113, 32'h00100093, 32'h00000013};
  localparam logic [LW-1:0] LINE2048 = {32'd3, 32'd2, 32'd1, 32'd0};
  localparam logic [LW-1:0] PAT_A5   = {16{8'hA5}};

  logic clk = 1'b0;
  logic reset;
  logic init_done = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   wr_count;

  logic [LW-1:0] ram [0:4095];

  // LATENCY=5 instance
  logic          ic_req, ic_ready, dc_req, dc_we, dc_ready, mem_we;
  logic [AW-1:0] ic_addr, dc_addr, mem_rd_addr, mem_wr_addr;
  logic [LW-1:0] ic_line, dc_line, dc_wdata, mem_rd_data, mem_wr_data;

  // LATENCY=1 instance
  logic          b_ic_req, b_ic_ready, b_dc_req, b_dc_we, b_dc_ready, b_mem_we;
  logic [AW-1:0] b_ic_addr, b_dc_addr, b_mem_rd_addr, b_mem_wr_addr;
  logic [LW-1:0] b_ic_line, b_dc_line, b_dc_wdata, b_mem_rd_data, b_mem_wr_data;

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] default_line(input int i);
    if (i == 0) return LINE0;
    if (i == 2048) return LINE2048;
    return {4{32'hDEAD0000 | 32'(i)}};
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 4096; i++) ram[i] <= default_line(i);
      wr_count <= 0;
    end else if (mem_we) begin
      ram[mem_wr_addr[11:0]] <= mem_wr_data;
      wr_count <= wr_count + 1;
    end
  end

  assign mem_rd_data   = ram[mem_rd_addr[11:0]];
  assign b_mem_rd_data = ram[b_mem_rd_addr[11:0]];

  mem_arbiter #(.LATENCY(5)) u_dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_line(ic_line),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready), .dc_line(dc_line),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_we(mem_we)
  );

  mem_arbiter #(.LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .ic_req(b_ic_req), .ic_addr(b_ic_addr), .ic_ready(b_ic_ready), .ic_line(b_ic_line),
    .dc_req(b_dc_req), .dc_we(b_dc_we), .dc_addr(b_dc_addr), .dc_wdata(b_dc_wdata),
    .dc_ready(b_dc_ready), .dc_line(b_dc_line),
    .mem_rd_addr(b_mem_rd_addr), .mem_rd_data(b_mem_rd_data),
    .mem_wr_addr(b_mem_wr_addr), .mem_wr_data(b_mem_wr_data), .mem_we(b_mem_we)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int seen;
    int steps;
    int exp_step [4];
    exp_step = '{6, 13, 20, 27};

    reset = 1'b0;
    ic_req = 0; ic_addr = '0; dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
    b_ic_req = 0; b_ic_addr = '0; b_dc_req = 0; b_dc_we = 0; b_dc_addr = '0; b_dc_wdata = '0;
    step();
    init_done = 1'b1;
    step();

    // Reset values
    chk("rst_ic_ready", LW'(ic_ready), '0);
    chk("rst_dc_ready", LW'(dc_ready), '0);
    chk("rst_mem_we", LW'(mem_we), '0);
    chk("rst_ic_line", ic_line, '0);
    chk("rst_dc_line", dc_line, '0);
    chk("rst_rd_addr", LW'(mem_rd_addr), '0);
    chk("rst_wr_addr", LW'(mem_wr_addr), '0);
    chk("rst_wr_data", mem_wr_data, '0);
    reset = 1'b1;
    step();

    // D-fill of line 2048; request dropped after grant still completes
    dc_req = 1; dc_we = 0; dc_addr = AW'(2048);
    step();
    dc_req = 0;
    step(); step(); step();
    chk("dfill_rd_addr", LW'(mem_rd_addr), LW'(2048));
    step();
    chk("dfill_early_ready", LW'(dc_ready), '0);
    step();
    chk("dfill_dc_ready", LW'(dc_ready), LW'(1));
    chk("dfill_ic_ready", LW'(ic_ready), '0);
    chk("dfill_line", dc_line, LINE2048);
    step();
    chk("dfill_ready_pulse", LW'(dc_ready), '0);

    // Writeback of line 10
    dc_req = 1; dc_we = 1; dc_addr = AW'(10); dc_wdata = PAT_A5;
    step();
    step(); step(); step();
    chk("wb_we_early", LW'(mem_we), '0);
    step();
    chk("wb_we", LW'(mem_we), LW'(1));
    chk("wb_wr_addr", LW'(mem_wr_addr), LW'(10));
    chk("wb_wr_data", mem_wr_data, PAT_A5);
    step();
    chk("wb_we_after", LW'(mem_we), '0);
    chk("wb_dc_ready", LW'(dc_ready), LW'(1));
    chk("wb_dc_line_kept", dc_line, LINE2048);
    dc_req = 0; dc_we = 0;
    step();
    chk("wb_count", LW'(wr_count), LW'(1));
    chk("wb_ram", ram[10], PAT_A5);

    // Fill of line 10 returns written data
    dc_req = 1; dc_addr = AW'(10);
    step();
    step(); step(); step(); step(); step();
    chk("refill_ready", LW'(dc_ready), LW'(1));
    chk("refill_line", dc_line, PAT_A5);
    dc_req = 0;
    step();

    // Contention after reset, held for four transactions: D, I, D, I
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    ic_req = 1; ic_addr = '0; dc_req = 1; dc_we = 0; dc_addr = AW'(2048);
    seen = 0;
    steps = 0;
    while (seen < 4 && steps < 40) begin
      step();
      steps++;
      if (ic_ready || dc_ready) begin
        chk("alt_ic_ready", LW'(ic_ready), LW'(seen % 2));
        chk("alt_dc_ready", LW'(dc_ready), LW'((seen + 1) % 2));
        chk("alt_step", LW'(steps), LW'(exp_step[seen]));
        if (seen % 2 == 1) chk("alt_ic_line", ic_line, LINE0);
        else chk("alt_dc_line", dc_line, LINE2048);
        seen++;
      end
    end
    chk("alt_count", LW'(seen), LW'(4));
    ic_req = 0; dc_req = 0;
    step();
    step();

    // Reset abort of a writeback at count 2
    dc_req = 1; dc_we = 1; dc_addr = AW'(20); dc_wdata = '1;
    step();
    step(); step();
    #2;
    reset = 1'b0;
    #1;
    chk("abort_mem_we", LW'(mem_we), '0);
    chk("abort_dc_ready", LW'(dc_ready), '0);
    chk("abort_dc_line", dc_line, '0);
    chk("abort_ic_line", ic_line, '0);
    chk("abort_rd_addr", LW'(mem_rd_addr), '0);
    chk("abort_wr_data", mem_wr_data, '0);
    dc_req = 0; dc_we = 0; dc_wdata = '0;
    step(); step();
    reset = 1'b1;
    step(); step(); step(); step(); step(); step(); step();
    chk("abort_wr_count", LW'(wr_count), LW'(1));
    chk("abort_ram", ram[20], default_line(20));
    chk("abort_idle_ready", LW'(dc_ready), '0);

    // LATENCY=1 instance
    b_ic_req = 1; b_ic_addr = '0;
    step();
    chk("l1_ready_e0", LW'(b_ic_ready), '0);
    step();
    chk("l1_ready", LW'(b_ic_ready), LW'(1));
    chk("l1_line", b_ic_line, LINE0);
    b_ic_addr = AW'(2048);
    step();
    chk("l1_resp_gap", LW'(b_ic_ready), '0);
    step();
    chk("l1_second_busy", LW'(b_ic_ready), '0);
    chk("l1_second_addr", LW'(b_mem_rd_addr), LW'(2048));
    step();
    chk("l1_second_ready", LW'(b_ic_ready), LW'(1));
    chk("l1_second_line", b_ic_line, LINE2048);
    chk("l1_no_dc_ready", LW'(b_dc_ready), '0);
    b_ic_req = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
